// File: rtl/params_pkg.sv
// Shared address/line/size types and the arbiter's state and owner encodings for mem_req_arbiter.
package params_pkg;

    localparam int unsigned PADDR_W = 32;
    localparam int unsigned LINE_W  = 128;

    typedef logic [PADDR_W-1:0] paddr_t;
    typedef logic [LINE_W-1:0]  cacheline_t;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_LINE} access_size_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DRAIN} arb_state_t;
    typedef enum logic [1:0] {OWN_IC, OWN_DC_RD, OWN_DC_WR} arb_owner_t;

    // Within the data class a store always beats a load; fetch wins only when favoured or alone.
    function automatic arb_owner_t pick_owner(input logic ic_rd, input logic dc_rd,
                                              input logic dc_wr, input logic ic_first);
        if (ic_rd && (ic_first || !(dc_rd || dc_wr))) return OWN_IC;
        if (dc_wr) return OWN_DC_WR;
        return OWN_DC_RD;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant timeout counter: cleared outside a grant, counts grant cycles, flags the last allowed one.
module mem_arb_timer #(
    parameter int unsigned Cycles = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Cycles) + 1;

    logic [CntW-1:0] count_q, count_d;

    assign expired_o = (count_q == CntW'(Cycles - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and load/store requests onto the single mem port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate priority between the fetch and data classes.
module mem_req_arbiter
    import params_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ic_rd_req_valid_i,
    input  paddr_t       ic_req_address_i,
    output logic         ic_data_valid_o,
    output cacheline_t   ic_data_o,
    input  logic         dc_rd_req_valid_i,
    input  logic         dc_wr_req_valid_i,
    input  paddr_t       dc_req_address_i,
    input  cacheline_t   dc_wr_data_i,
    input  access_size_t dc_access_size_i,
    output logic         dc_data_valid_o,
    output cacheline_t   dc_data_o,
    output logic         dc_write_done_o,
    output logic         mem_rd_req_valid_o,
    output logic         mem_wr_req_valid_o,
    output logic         mem_req_is_instr_o,
    output paddr_t       mem_req_address_o,
    output cacheline_t   mem_wr_data_o,
    output access_size_t mem_access_size_o,
    input  logic         mem_data_valid_i,
    input  logic         mem_data_is_instr_i,
    input  cacheline_t   mem_data_i,
    input  logic         mem_write_done_i,
    output logic         err_o
);

    arb_state_t   state_q, state_d;
    arb_owner_t   owner_q, owner_d;
    arb_owner_t   winner;
    logic         mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, is_instr_q, is_instr_d;
    paddr_t       addr_q, addr_d;
    cacheline_t   wdata_q, wdata_d;
    access_size_t size_q, size_d;
    logic         err_q, err_d;
    logic         in_grant, any_req, rd_rsp, wr_rsp, rsp_done, owner_mismatch, timer_expired;

    assign in_grant = (state_q == ARB_GRANT);
    assign any_req  = ic_rd_req_valid_i | dc_rd_req_valid_i | dc_wr_req_valid_i;

    // Responses only count while granted and only for the matching request kind.
    assign rd_rsp         = in_grant && (owner_q != OWN_DC_WR) && mem_data_valid_i;
    assign wr_rsp         = in_grant && (owner_q == OWN_DC_WR) && mem_write_done_i;
    assign rsp_done       = rd_rsp | wr_rsp;
    assign owner_mismatch = rd_rsp && (mem_data_is_instr_i != (owner_q == OWN_IC));

    assign ic_data_valid_o = rd_rsp && (owner_q == OWN_IC);
    assign ic_data_o       = ic_data_valid_o ? mem_data_i : '0;
    assign dc_data_valid_o = rd_rsp && (owner_q == OWN_DC_RD);
    assign dc_data_o       = dc_data_valid_o ? mem_data_i : '0;
    assign dc_write_done_o = wr_rsp;

    assign mem_rd_req_valid_o = mem_rd_q;
    assign mem_wr_req_valid_o = mem_wr_q;
    assign mem_req_is_instr_o = is_instr_q;
    assign mem_req_address_o  = addr_q;
    assign mem_wr_data_o      = wdata_q;
    assign mem_access_size_o  = size_q;
    assign err_o              = err_q;

    mem_arb_timer #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!in_grant),
        .en_i      (in_grant),
        .expired_o (timer_expired)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ic_first_q, ic_first_d;

    // Whichever class just finished hands preference to the other one.
    assign ic_first_d = (in_grant && (state_d == ARB_DRAIN)) ? (owner_q != OWN_IC) : ic_first_q;
    assign winner = pick_owner(ic_rd_req_valid_i, dc_rd_req_valid_i, dc_wr_req_valid_i,
                               ic_first_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ic_first_q <= 1'b0;
        end else begin
            ic_first_q <= ic_first_d;
        end
    end
`else
    assign winner = pick_owner(ic_rd_req_valid_i, dc_rd_req_valid_i, dc_wr_req_valid_i, 1'b0);
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        is_instr_d = is_instr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        err_d      = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d    = ARB_GRANT;
                    owner_d    = winner;
                    mem_rd_d   = (winner != OWN_DC_WR);
                    mem_wr_d   = (winner == OWN_DC_WR);
                    is_instr_d = (winner == OWN_IC);
                    addr_d     = (winner == OWN_IC) ? ic_req_address_i : dc_req_address_i;
                    wdata_d    = (winner == OWN_DC_WR) ? dc_wr_data_i : '0;
                    size_d     = (winner == OWN_IC) ? SIZE_LINE : dc_access_size_i;
                    if (dc_rd_req_valid_i && dc_wr_req_valid_i) err_d = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (owner_mismatch) err_d = 1'b1;
                if (rsp_done || timer_expired) begin
                    state_d    = ARB_DRAIN;
                    mem_rd_d   = 1'b0;
                    mem_wr_d   = 1'b0;
                    is_instr_d = 1'b0;
                    addr_d     = '0;
                    wdata_d    = '0;
                    size_d     = SIZE_BYTE;
                    if (!rsp_done) err_d = 1'b1;
                end
            end
            ARB_DRAIN: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IC;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            is_instr_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            is_instr_q <= is_instr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            err_q      <= err_d;
        end
    end

endmodule
